// File: rtl/actor_pkg.sv
// Shared types and helpers for the tile-aligned actor mover.
package actor_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    MOVE,
    ARRIVE
  } mv_state_t;

  localparam int MAP_PASS_BIT = 0;
  localparam int MAP_BEAN_BIT = 1;

  // Encoding pairs UP/DOWN and LEFT/RIGHT on bit 0.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

  function automatic dir_t btn_to_dir(input logic [3:0] btn_n);
    dir_t d;
    d = DIR_RIGHT;
    if (!btn_n[3])      d = DIR_UP;
    else if (!btn_n[2]) d = DIR_DOWN;
    else if (!btn_n[1]) d = DIR_LEFT;
    return d;
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Divides clk by STEP_DIV while enabled; the count restarts whenever disabled.
module step_tick_gen #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || cnt_q == LAST) cnt_d = '0;
    else                        cnt_d = cnt_q + CW'(1);
  end

  assign tick_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/grid_actor_mover.sv
// Tile-aligned actor movement engine with buffered direction requests and bean scoring.
// Define WRAP_TUNNEL_EN to let the left/right map edges wrap to the opposite column.
module grid_actor_mover
  import actor_pkg::*;
#(
  parameter int MAP_W     = 32,
  parameter int MAP_H     = 24,
  parameter int TILE_SIZE = 20,
  parameter int SPEED     = 5,
  parameter int STEP_DIV  = 4,
  parameter int START_TX  = 1,
  parameter int START_TY  = 1,
  parameter int X_W       = $clog2(MAP_W * TILE_SIZE),
  parameter int Y_W       = $clog2(MAP_H * TILE_SIZE),
  parameter int A_W       = $clog2(MAP_W * MAP_H)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     btn_n,
  output logic           map_rd_en,
  output logic [A_W-1:0] map_rd_addr,
  input  logic [1:0]     map_rd_data,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [1:0]     dir,
  output logic           moving,
  output logic           bean_clr_valid,
  output logic [A_W-1:0] bean_clr_addr,
  output logic [15:0]    score
);

  localparam int TX_W    = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int TY_W    = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int OFF_W   = $clog2(TILE_SIZE + 1);
  localparam int WORLD_W = MAP_W * TILE_SIZE;

  if (TILE_SIZE % SPEED != 0) begin : g_bad_speed
    $error("grid_actor_mover: TILE_SIZE must be a multiple of SPEED");
  end
  if (STEP_DIV < 1) begin : g_bad_div
    $error("grid_actor_mover: STEP_DIV must be at least 1");
  end

  function automatic logic [A_W-1:0] tile_addr(input logic [TX_W-1:0] tx,
                                                input logic [TY_W-1:0] ty);
    return A_W'(int'(ty) * MAP_W + int'(tx));
  endfunction

  mv_state_t       state_q, state_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  dir_t            dir_q, dir_d;
  logic [TX_W-1:0] tx_q, tx_d, tgt_x_q, tgt_x_d;
  logic [TY_W-1:0] ty_q, ty_d, tgt_y_q, tgt_y_d;
  logic [OFF_W-1:0] off_q, off_d, off_step;
  dir_t            cand_q, cand_d;
  logic            cand_req_q, cand_req_d;
  logic            edge_q, edge_d;
  logic            bean_q, bean_d;
  logic            last_ok_q, last_ok_d;
  logic            req_valid_q, req_valid_d;
  dir_t            req_dir_q, req_dir_d;
  logic [15:0]     score_q, score_d;

  logic            tick;
  logic            consume;
  dir_t            idle_cand;
  logic [TX_W-1:0] nx;
  logic [TY_W-1:0] ny;
  logic            n_edge;
  logic [X_W-1:0]  x_inc, x_dec;

  step_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q == MOVE),
    .tick_o (tick)
  );

  assign idle_cand = req_valid_q ? req_dir_q : dir_q;

  always_comb begin
    nx     = tx_q;
    ny     = ty_q;
    n_edge = 1'b0;
    unique case (idle_cand)
      DIR_UP: begin
        if (ty_q == '0) n_edge = 1'b1;
        else            ny = ty_q - TY_W'(1);
      end
      DIR_DOWN: begin
        if (ty_q == TY_W'(MAP_H - 1)) n_edge = 1'b1;
        else                          ny = ty_q + TY_W'(1);
      end
      DIR_LEFT: begin
        if (tx_q == '0) begin
`ifdef WRAP_TUNNEL_EN
          nx = TX_W'(MAP_W - 1);
`else
          n_edge = 1'b1;
`endif
        end else begin
          nx = tx_q - TX_W'(1);
        end
      end
      DIR_RIGHT: begin
        if (tx_q == TX_W'(MAP_W - 1)) begin
`ifdef WRAP_TUNNEL_EN
          nx = '0;
`else
          n_edge = 1'b1;
`endif
        end else begin
          nx = tx_q + TX_W'(1);
        end
      end
    endcase
  end

`ifdef WRAP_TUNNEL_EN
  assign x_inc = (int'(x_q) + SPEED >= WORLD_W) ? X_W'(int'(x_q) + SPEED - WORLD_W)
                                                : X_W'(int'(x_q) + SPEED);
  assign x_dec = (int'(x_q) < SPEED) ? X_W'(int'(x_q) + WORLD_W - SPEED)
                                     : X_W'(int'(x_q) - SPEED);
`else
  assign x_inc = x_q + X_W'(SPEED);
  assign x_dec = x_q - X_W'(SPEED);
`endif

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    dir_d          = dir_q;
    tx_d           = tx_q;
    ty_d           = ty_q;
    tgt_x_d        = tgt_x_q;
    tgt_y_d        = tgt_y_q;
    off_d          = off_q;
    off_step       = off_q;
    cand_d         = cand_q;
    cand_req_d     = cand_req_q;
    edge_d         = edge_q;
    bean_d         = bean_q;
    last_ok_d      = last_ok_q;
    score_d        = score_q;
    consume        = 1'b0;
    map_rd_en      = 1'b0;
    map_rd_addr    = '0;
    bean_clr_valid = 1'b0;
    bean_clr_addr  = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid_q || last_ok_q) begin
          cand_d      = idle_cand;
          cand_req_d  = req_valid_q;
          edge_d      = n_edge;
          tgt_x_d     = nx;
          tgt_y_d     = ny;
          map_rd_en   = !n_edge;
          map_rd_addr = n_edge ? '0 : tile_addr(nx, ny);
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (req_valid_q && req_dir_q == cand_q) consume = 1'b1;
        if (!edge_q && map_rd_data[MAP_PASS_BIT]) begin
          dir_d   = cand_q;
          bean_d  = map_rd_data[MAP_BEAN_BIT];
          off_d   = '0;
          state_d = MOVE;
        end else begin
          // A refused turn keeps cruising; a refused straight-ahead move stops.
          if (!cand_req_q) last_ok_d = 1'b0;
          state_d = IDLE;
        end
      end
      MOVE: begin
        if (tick) begin
          off_step = OFF_W'(int'(off_q) + SPEED);
          if (req_valid_q && req_dir_q == opposite(dir_q) && off_q != '0) begin
            // Reverse toward the tile just left: swap origin/target, remaining distance flips.
            consume  = 1'b1;
            dir_d    = opposite(dir_q);
            tx_d     = tgt_x_q;
            ty_d     = tgt_y_q;
            tgt_x_d  = tx_q;
            tgt_y_d  = ty_q;
            bean_d   = 1'b0;
            off_step = OFF_W'(TILE_SIZE - int'(off_q) + SPEED);
          end
          off_d = off_step;
          unique case (dir_d)
            DIR_UP:    y_d = y_q - Y_W'(SPEED);
            DIR_DOWN:  y_d = y_q + Y_W'(SPEED);
            DIR_LEFT:  x_d = x_dec;
            DIR_RIGHT: x_d = x_inc;
          endcase
          if (off_step == OFF_W'(TILE_SIZE)) state_d = ARRIVE;
        end
      end
      ARRIVE: begin
        bean_clr_valid = bean_q;
        bean_clr_addr  = bean_q ? tile_addr(tgt_x_q, tgt_y_q) : '0;
        if (bean_q && score_q != 16'hFFFF) score_d = score_q + 16'd1;
        tx_d      = tgt_x_q;
        ty_d      = tgt_y_q;
        off_d     = '0;
        bean_d    = 1'b0;
        last_ok_d = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  always_comb begin
    req_valid_d = req_valid_q;
    req_dir_d   = req_dir_q;
    if (consume) req_valid_d = 1'b0;
    if (btn_n != 4'hF) begin
      req_valid_d = 1'b1;
      req_dir_d   = btn_to_dir(btn_n);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= X_W'(START_TX * TILE_SIZE);
      y_q         <= Y_W'(START_TY * TILE_SIZE);
      dir_q       <= DIR_UP;
      tx_q        <= TX_W'(START_TX);
      ty_q        <= TY_W'(START_TY);
      tgt_x_q     <= TX_W'(START_TX);
      tgt_y_q     <= TY_W'(START_TY);
      off_q       <= '0;
      cand_q      <= DIR_UP;
      cand_req_q  <= 1'b0;
      edge_q      <= 1'b0;
      bean_q      <= 1'b0;
      last_ok_q   <= 1'b0;
      req_valid_q <= 1'b0;
      req_dir_q   <= DIR_UP;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      tgt_x_q     <= tgt_x_d;
      tgt_y_q     <= tgt_y_d;
      off_q       <= off_d;
      cand_q      <= cand_d;
      cand_req_q  <= cand_req_d;
      edge_q      <= edge_d;
      bean_q      <= bean_d;
      last_ok_q   <= last_ok_d;
      req_valid_q <= req_valid_d;
      req_dir_q   <= req_dir_d;
      score_q     <= score_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign dir    = dir_q;
  assign moving = (state_q == MOVE);
  assign score  = score_q;

endmodule

// File: tb/tb_grid_actor_mover.sv
// Directed bench for grid_actor_mover with a 1-cycle-latency tilemap model.
module tb_grid_actor_mover;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  btn_n = 4'hF;
  logic        map_rd_en;
  logic [9:0]  map_rd_addr;
  logic [1:0]  map_rd_data;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [1:0]  dir;
  logic        moving;
  logic        bean_clr_valid;
  logic [9:0]  bean_clr_addr;
  logic [15:0] score;

  logic [1:0]  map_mem [0:767];
  int errors = 0;
  int checks = 0;

  grid_actor_mover dut (
    .clk            (clk),
    .reset          (reset),
    .btn_n          (btn_n),
    .map_rd_en      (map_rd_en),
    .map_rd_addr    (map_rd_addr),
    .map_rd_data    (map_rd_data),
    .x              (x),
    .y              (y),
    .dir            (dir),
    .moving         (moving),
    .bean_clr_valid (bean_clr_valid),
    .bean_clr_addr  (bean_clr_addr),
    .score          (score)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (map_rd_en) map_rd_data <= map_mem[map_rd_addr];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sig(input int which);
    case (which)
      0:       return int'(x);
      1:       return int'(y);
      2:       return int'(map_rd_en);
      default: return int'(bean_clr_valid);
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int which, input int val, input int budget);
    int n = 0;
    while (sig(which) != val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, sig(which), val);
  endtask

  task automatic do_reset();
    btn_n = 4'hF;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse(input logic [3:0] b);
    btn_n = b;
    @(negedge clk);
    btn_n = 4'hF;
  endtask

  initial begin
    int extra;
    for (int i = 0; i < 768; i++) map_mem[i] = 2'b01;

    // Reset state
    @(negedge clk);
    check("rst_x", int'(x), 20);
    check("rst_y", int'(y), 20);
    check("rst_dir", int'(dir), 0);
    check("rst_moving", int'(moving), 0);
    check("rst_rd_en", int'(map_rd_en), 0);
    check("rst_rd_addr", int'(map_rd_addr), 0);
    check("rst_bean_v", int'(bean_clr_valid), 0);
    check("rst_bean_a", int'(bean_clr_addr), 0);
    check("rst_score", int'(score), 0);
    reset = 1'b1;

    // 1: hold right, open map
    btn_n = 4'b1110;
    @(negedge clk);
    check("t1_rd_en", int'(map_rd_en), 1);
    check("t1_rd_addr", int'(map_rd_addr), 34);
    @(negedge clk);
    check("t1_wait_moving", int'(moving), 0);
    @(negedge clk);
    check("t1_moving", int'(moving), 1);
    check("t1_dir", int'(dir), 3);
    check("t1_x0", int'(x), 20);
    for (int k = 1; k <= 4; k++) begin
      repeat (4) @(negedge clk);
      check("t1_step_x", int'(x), 20 + 5 * k);
    end
    check("t1_arrive_moving", int'(moving), 0);
    @(negedge clk);
    check("t1_next_rd_en", int'(map_rd_en), 1);
    check("t1_next_rd_addr", int'(map_rd_addr), 35);

    // Async reset mid-move snaps to the start tile
    btn_n = 4'hF;
    #2 reset = 1'b0;
    #1;
    check("async_rst_x", int'(x), 20);
    check("async_rst_moving", int'(moving), 0);

    // 2: wall to the right
    map_mem[34] = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    pulse(4'b1110);
    check("t2_rd_addr", int'(map_rd_addr), 34);
    repeat (2) @(negedge clk);
    check("t2_moving", int'(moving), 0);
    check("t2_x", int'(x), 20);
    repeat (10) @(negedge clk);
    check("t2_no_retry", int'(map_rd_en), 0);
    check("t2_x_hold", int'(x), 20);

    // 3: bean on the tile to the right
    do_reset();
    map_mem[34] = 2'b11;
    pulse(4'b1110);
    wait_sig("t3_bean_pulse", 3, 1, 100);
    check("t3_x", int'(x), 40);
    check("t3_bean_addr", int'(bean_clr_addr), 34);
    @(negedge clk);
    check("t3_score", int'(score), 1);
    check("t3_pulse_once", int'(bean_clr_valid), 0);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (bean_clr_valid) extra++;
    end
    check("t3_extra_pulses", extra, 0);
    check("t3_score_hold", int'(score), 1);

    // 4: reverse mid-tile; target bean must be ignored
    do_reset();
    map_mem[34] = 2'b11;
    pulse(4'b1110);
    wait_sig("t4_reach30", 0, 30, 40);
    pulse(4'b1101);
    wait_sig("t4_rev25", 0, 25, 10);
    check("t4_dir", int'(dir), 2);
    wait_sig("t4_back20", 0, 20, 10);
    wait_sig("t4_reach0", 0, 0, 60);
    check("t4_score", int'(score), 0);

    // 6: left edge of the map
`ifdef WRAP_TUNNEL_EN
    wait_sig("t6_wrap635", 0, 635, 20);
    check("t6_dir", int'(dir), 2);
    check("t6_moving", int'(moving), 1);
    wait_sig("t6_wrap620", 0, 620, 30);
`else
    repeat (20) @(negedge clk);
    check("t6_edge_x", int'(x), 0);
    check("t6_edge_moving", int'(moving), 0);
    check("t6_edge_dir", int'(dir), 2);
`endif

    // 5a: buffered up-turn taken at next aligned tile
    do_reset();
    map_mem[34] = 2'b01;
    pulse(4'b1110);
    wait_sig("t5a_x25", 0, 25, 40);
    pulse(4'b0111);
    check("t5a_still_right", int'(dir), 3);
    wait_sig("t5a_x40", 0, 40, 30);
    wait_sig("t5a_rd", 2, 1, 5);
    check("t5a_rd_addr", int'(map_rd_addr), 2);
    wait_sig("t5a_y15", 1, 15, 20);
    check("t5a_x", int'(x), 40);
    check("t5a_dir", int'(dir), 0);

    // 5b: tile above blocked -> keep going right
    do_reset();
    map_mem[2] = 2'b00;
    pulse(4'b1110);
    wait_sig("t5b_x25", 0, 25, 40);
    pulse(4'b0111);
    wait_sig("t5b_x40", 0, 40, 30);
    wait_sig("t5b_rd", 2, 1, 5);
    check("t5b_rd_addr", int'(map_rd_addr), 2);
    @(negedge clk);
    wait_sig("t5b_rd2", 2, 1, 5);
    check("t5b_rd2_addr", int'(map_rd_addr), 35);
    wait_sig("t5b_x45", 0, 45, 20);
    check("t5b_dir", int'(dir), 3);
    check("t5b_y", int'(y), 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
